// File: rtl/uio_arb_pkg.sv
// Shared definitions for the uio pad arbiter: FSM encoding and default parameters.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_MAX_HOLD    = 8;
    localparam int DEF_TURN_CYCLES = 1;

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               valid,
    output logic [PW-1:0]      index,
    output logic [NUM_REQ-1:0] onehot
);

    int cand;

    // Scan from the farthest offset down so the nearest-to-ptr request wins last.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        cand   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req[cand]) begin
                valid = 1'b1;
                index = PW'(cand);
            end
        end
        if (valid) onehot[index] = 1'b1;
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pads with bounded hold and a forced idle turnaround.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] wdata,
    input  logic [NUM_REQ*8-1:0] woe,
    input  logic [7:0]           uio_in,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

    // Handshake: req is a level held by a requester for as long as it wants the pads;
    // gnt[k] high means requester k drives uio_out/uio_oe this cycle. Dropping req ends
    // ownership, and ownership is also withdrawn on timeout or ena low, whatever req says.

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [TW-1:0]        turn_q, turn_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;

    logic                 pick_valid;
    logic [PW-1:0]        pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .index  (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            gnt_q   <= '0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            gnt_q   <= gnt_d;
            rdata   <= uio_in;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ena && pick_valid) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    gnt_d   = pick_onehot;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (!req[owner_q] || !ena || hold_q == HOLD_LAST) begin
                    state_d = ST_TURN;
                    gnt_d   = '0;
                    hold_d  = '0;
                    turn_d  = '0;
                    // Owner just served drops to lowest priority for the next round.
                    ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = ST_IDLE;
                    turn_d  = '0;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        uio_out = '0;
        uio_oe  = '0;
        if (state_q == ST_GRANT) begin
            uio_out = wdata[8*int'(owner_q) +: 8];
            uio_oe  = woe[8*int'(owner_q) +: 8];
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter (NUM_REQ=4, MAX_HOLD=8, TURN_CYCLES=1).
module tb_uio_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [31:0] woe;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [3:0]  gnt;
    logic [7:0]  rdata;
    logic        busy;
    logic [1:0]  state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;
    logic       chk_en = 1'b0;
    logic [7:0] exp_rdata = 8'h00;

    uio_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .TURN_CYCLES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .wdata     (wdata),
        .woe       (woe),
        .uio_in    (uio_in),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe),
        .gnt       (gnt),
        .rdata     (rdata),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // rdata is uio_in one edge late; gnt one-hot or zero; pads released with no owner
    always @(posedge clk) exp_rdata <= rst_n ? uio_in : 8'h00;

    always @(negedge clk) begin
        if (chk_en) begin
            tests_run++;
            if (rdata !== exp_rdata) begin
                tests_failed++;
                $display("FAIL rdata: got %h want %h", rdata, exp_rdata);
            end
            tests_run++;
            if (!$onehot0(gnt) || (gnt == 4'b0 && uio_oe !== 8'h00)) begin
                tests_failed++;
                $display("FAIL gnt_invariant: gnt %b uio_oe %h want onehot0 and oe 00 when idle", gnt, uio_oe);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        uio_in = uio_in + 8'h3B;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] woe_of(input int k);
        logic [31:0] w;
        w = woe;
        return w[8*k +: 8];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        chk_en = 1'b1;
        tests_run++;
        if (gnt !== 4'b0 || uio_oe !== 8'h00 || uio_out !== 8'h00 || busy !== 1'b0 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset: gnt %b oe %h out %h busy %b st %0d want all zero", gnt, uio_oe, uio_out, busy, state_dbg);
        end
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
        tests_run++;
        if (gnt !== 4'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: gnt %b busy %b want 0000 0", gnt, busy);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        for (int c = 1; c <= 3; c++) begin
            tests_run++;
            if (gnt !== 4'b0100 || uio_out !== 8'hA5 || uio_oe !== 8'hFF || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_grant c%0d: gnt %b out %h oe %h busy %b want 0100 a5 ff 1", c, gnt, uio_out, uio_oe, busy);
            end
            if (c == 3) req = 4'b0000;
            tick();
        end
        tests_run++;
        if (gnt !== 4'b0 || uio_oe !== 8'h00 || uio_out !== 8'h00 || busy !== 1'b1 || state_dbg !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_turn: gnt %b oe %h out %h busy %b st %0d want 0000 00 00 1 2", gnt, uio_oe, uio_out, busy, state_dbg);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_idle: busy %b st %0d want 0 0", busy, state_dbg);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [5];
        int idx [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        idx[0] = 0; idx[1] = 1; idx[2] = 2; idx[3] = 3; idx[4] = 0;
        do_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                tests_run++;
                if (gnt !== seq[g] || uio_oe !== woe_of(idx[g])) begin
                    tests_failed++;
                    $display("FAIL rr_grant g%0d c%0d: gnt %b oe %h want %b %h", g, c, gnt, uio_oe, seq[g], woe_of(idx[g]));
                end
                if (g == 4 && c == 7) req = 4'b0000;
                tick();
            end
            for (int c = 0; c < 2; c++) begin
                tests_run++;
                if (gnt !== 4'b0 || uio_oe !== 8'h00) begin
                    tests_failed++;
                    $display("FAIL rr_gap g%0d c%0d: gnt %b oe %h want 0000 00", g, c, gnt, uio_oe);
                end
                tick();
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_g;
        req = 4'b0001;
        tick();
        for (int c = 0; c < 25; c++) begin
            exp_g = ((c % 10) < 8) ? 4'b0001 : 4'b0000;
            tests_run++;
            if (gnt !== exp_g) begin
                tests_failed++;
                $display("FAIL timeout c%0d: gnt %b want %b", c, gnt, exp_g);
            end
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_ena();
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        tick();
        tests_run++;
        if (gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL ena_pre: gnt %b want 0001", gnt);
        end
        ena = 1'b0;
        tick();
        tests_run++;
        if (gnt !== 4'b0 || uio_oe !== 8'h00) begin
            tests_failed++;
            $display("FAIL ena_release: gnt %b oe %h want 0000 00", gnt, uio_oe);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            tests_run++;
            if (gnt !== 4'b0) begin
                tests_failed++;
                $display("FAIL ena_low c%0d: gnt %b want 0000", c, gnt);
            end
        end
        ena = 1'b1;
        tick();
        tests_run++;
        if (gnt !== 4'b0010 || uio_out !== 8'hB2) begin
            tests_failed++;
            $display("FAIL ena_resume: gnt %b out %h want 0010 b2", gnt, uio_out);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b0100;
        tick();
        tick();
        tests_run++;
        if (gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL midrst_pre: gnt %b want 0100", gnt);
        end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (gnt !== 4'b0 || uio_oe !== 8'h00 || uio_out !== 8'h00 || rdata !== 8'h00 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst: gnt %b oe %h out %h rdata %h busy %b want all zero", gnt, uio_oe, uio_out, rdata, busy);
        end
        rst_n = 1'b1;
        req   = 4'b1010;
        tick();
        tests_run++;
        if (gnt !== 4'b0010 || uio_oe !== 8'hF0) begin
            tests_failed++;
            $display("FAIL midrst_regrant: gnt %b oe %h want 0010 f0", gnt, uio_oe);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = 4'b0000;
        wdata  = {8'hD4, 8'hA5, 8'hB2, 8'hC1};
        woe    = {8'h0F, 8'hFF, 8'hF0, 8'h3C};
        uio_in = 8'h11;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_ena();
        test_reset_mid_grant();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
